// File: rtl/hash_table_bucketed_pkg.sv
// Shared types and row-field helpers for the bucketed build/probe hash table.
// Helpers take widths as arguments and work on a wide scratch vector; callers size-cast the result.
package hash_table_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_BUILD_IDLE,
        ST_BUILD_WR,
        ST_PROBE_IDLE,
        ST_PROBE_RD,
        ST_PROBE_EMIT
    } state_e;

    // Upper bounds on row / tuple / count widths the helpers can handle.
    localparam int unsigned ROW_MAX_W   = 2048;
    localparam int unsigned TUPLE_MAX_W = 512;
    localparam int unsigned CNT_MAX_W   = 16;

    function automatic logic [TUPLE_MAX_W-1:0] row_slot(
        input logic [ROW_MAX_W-1:0] row,
        input int unsigned          tuple_w,
        input int unsigned          slot
    );
        return TUPLE_MAX_W'(row >> (slot * tuple_w));
    endfunction

    // The fill count sits directly above the last slot.
    function automatic logic [CNT_MAX_W-1:0] row_count(
        input logic [ROW_MAX_W-1:0] row,
        input int unsigned          tuple_w,
        input int unsigned          slots
    );
        return CNT_MAX_W'(row >> (slots * tuple_w));
    endfunction

endpackage

// File: rtl/hash_table_bucketed_slot_match_encoder.sv
// Lowest-set-bit encoder over the per-slot match mask (one-hot and binary index).
module slot_match_encoder #(
    parameter int unsigned  SLOTS     = 4,
    localparam int unsigned IDX_WIDTH = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0]     mask,
    output logic [SLOTS-1:0]     onehot,
    output logic [IDX_WIDTH-1:0] idx
);

    logic found;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (mask[i] && !found) begin
                onehot[i] = 1'b1;
                idx       = IDX_WIDTH'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_dual_port_ram_single_clock.sv
// Single-clock simple dual-port RAM: one write port, one read port, 1-cycle registered read.
module simple_dual_port_ram_single_clock #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/hash_table_bucketed.sv
// Build/probe hash table for one join partition: each RAM row holds a fill count and SLOTS tuples.
// Builds read-modify-write a row in two cycles; probes emit every key match, one per cycle.
module hash_table_bucketed
    import hash_table_pkg::*;
#(
    parameter int unsigned TUPLE_WIDTH = 64,
    parameter int unsigned KEY_WIDTH   = 32,
    parameter int unsigned ROW_BITS    = 3,
    parameter int unsigned SLOTS       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     build_valid,
    output logic                     build_ready,
    input  logic [TUPLE_WIDTH-1:0]   build_tuple,
    input  logic [31:0]              build_hash,
    input  logic                     start_probe,
    input  logic                     probe_valid,
    output logic                     probe_ready,
    input  logic [TUPLE_WIDTH-1:0]   probe_tuple,
    input  logic [31:0]              probe_hash,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*TUPLE_WIDTH-1:0] out_tuple,
    output logic [31:0]              overflow_count,
    output logic                     init_done
);

    localparam int unsigned CNT_WIDTH = $clog2(SLOTS + 1);
    localparam int unsigned ROW_WIDTH = CNT_WIDTH + SLOTS * TUPLE_WIDTH;
    localparam int unsigned IDX_WIDTH = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_e                 state_q, state_d;
    logic [ROW_BITS-1:0]    init_row_q, init_row_d;
    logic [ROW_BITS-1:0]    row_q, row_d;
    logic [TUPLE_WIDTH-1:0] build_tuple_q, build_tuple_d;
    logic [TUPLE_WIDTH-1:0] probe_tuple_q, probe_tuple_d;
    logic [SLOTS-1:0]       mask_q, mask_d;
    logic [TUPLE_WIDTH-1:0] slot_q [SLOTS];
    logic [TUPLE_WIDTH-1:0] slot_d [SLOTS];
    logic [31:0]            overflow_q, overflow_d;

    logic                   ram_we;
    logic [ROW_BITS-1:0]    ram_waddr, ram_raddr;
    logic [ROW_WIDTH-1:0]   ram_wdata, ram_rdata;

    logic [TUPLE_WIDTH-1:0] rd_slot [SLOTS];
    logic [CNT_WIDTH-1:0]   rd_count;
    logic [SLOTS-1:0]       rd_mask;
    logic [ROW_WIDTH-1:0]   new_row;
    logic [SLOTS-1:0]       enc_onehot;
    logic [IDX_WIDTH-1:0]   enc_idx;
    logic [SLOTS-1:0]       mask_next;
    logic                   build_hs, probe_hs;
    logic                   unused_hash_bits;

    assign unused_hash_bits = ^{build_hash[31:ROW_BITS], probe_hash[31:ROW_BITS]};

    simple_dual_port_ram_single_clock #(
        .DATA_WIDTH (ROW_WIDTH),
        .ADDR_WIDTH (ROW_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    slot_match_encoder #(
        .SLOTS (SLOTS)
    ) u_enc (
        .mask   (mask_q),
        .onehot (enc_onehot),
        .idx    (enc_idx)
    );

    assign init_done      = (state_q != ST_INIT);
    assign build_ready    = (state_q == ST_BUILD_IDLE) && !start_probe;
    assign probe_ready    = (state_q == ST_PROBE_IDLE) && !clear;
    assign out_valid      = (state_q == ST_PROBE_EMIT);
    assign out_tuple      = (state_q == ST_PROBE_EMIT) ? {slot_q[enc_idx], probe_tuple_q} : '0;
    assign overflow_count = overflow_q;
    assign build_hs       = build_valid && build_ready;
    assign probe_hs       = probe_valid && probe_ready;
    assign mask_next      = mask_q & ~enc_onehot;
    assign ram_raddr      = (state_q == ST_PROBE_IDLE) ? probe_hash[ROW_BITS-1:0]
                                                       : build_hash[ROW_BITS-1:0];

    always_comb begin
        rd_mask  = '0;
        rd_count = CNT_WIDTH'(row_count(ROW_MAX_W'(ram_rdata), TUPLE_WIDTH, SLOTS));
        for (int unsigned s = 0; s < SLOTS; s++) begin
            rd_slot[s] = TUPLE_WIDTH'(row_slot(ROW_MAX_W'(ram_rdata), TUPLE_WIDTH, s));
            rd_mask[s] = (CNT_WIDTH'(s) < rd_count) &&
                         (rd_slot[s][KEY_WIDTH-1:0] == probe_tuple_q[KEY_WIDTH-1:0]);
        end
    end

    // Updated row for a non-full insert: new tuple lands in slot[count], other slots pass through.
    always_comb begin
        new_row = ram_rdata;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            if (CNT_WIDTH'(s) == rd_count) begin
                new_row[s*TUPLE_WIDTH +: TUPLE_WIDTH] = build_tuple_q;
            end
        end
        new_row[ROW_WIDTH-1 -: CNT_WIDTH] = rd_count + CNT_WIDTH'(1);
    end

    always_comb begin
        state_d       = state_q;
        init_row_d    = init_row_q;
        row_d         = row_q;
        build_tuple_d = build_tuple_q;
        probe_tuple_d = probe_tuple_q;
        mask_d        = mask_q;
        slot_d        = slot_q;
        overflow_d    = overflow_q;
        ram_we        = 1'b0;
        ram_waddr     = row_q;
        ram_wdata     = new_row;

        case (state_q)
            ST_INIT: begin
                ram_we     = 1'b1;
                ram_waddr  = init_row_q;
                ram_wdata  = '0;
                init_row_d = init_row_q + ROW_BITS'(1);
                if (init_row_q == '1) begin
                    state_d = ST_BUILD_IDLE;
                end
            end
            ST_BUILD_IDLE: begin
                if (start_probe) begin
                    state_d = ST_PROBE_IDLE;
                end else if (build_hs) begin
                    build_tuple_d = build_tuple;
                    row_d         = build_hash[ROW_BITS-1:0];
                    state_d       = ST_BUILD_WR;
                end
            end
            ST_BUILD_WR: begin
                if (rd_count < CNT_WIDTH'(SLOTS)) begin
                    ram_we = 1'b1;
                end else if (overflow_q != '1) begin
                    overflow_d = overflow_q + 32'd1;
                end
                state_d = ST_BUILD_IDLE;
            end
            ST_PROBE_IDLE: begin
                if (clear) begin
                    state_d    = ST_INIT;
                    init_row_d = '0;
                    overflow_d = '0;
                end else if (probe_hs) begin
                    probe_tuple_d = probe_tuple;
                    state_d       = ST_PROBE_RD;
                end
            end
            ST_PROBE_RD: begin
                mask_d  = rd_mask;
                slot_d  = rd_slot;
                state_d = (rd_mask == '0) ? ST_PROBE_IDLE : ST_PROBE_EMIT;
            end
            ST_PROBE_EMIT: begin
                if (out_ready) begin
                    mask_d = mask_next;
                    if (mask_next == '0) begin
                        state_d = ST_PROBE_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            init_row_q    <= '0;
            row_q         <= '0;
            build_tuple_q <= '0;
            probe_tuple_q <= '0;
            mask_q        <= '0;
            overflow_q    <= '0;
            for (int unsigned s = 0; s < SLOTS; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            state_q       <= state_d;
            init_row_q    <= init_row_d;
            row_q         <= row_d;
            build_tuple_q <= build_tuple_d;
            probe_tuple_q <= probe_tuple_d;
            mask_q        <= mask_d;
            overflow_q    <= overflow_d;
            slot_q        <= slot_d;
        end
    end

endmodule
